// File: rtl/bitarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bitarb_pkg
//  Brief    : Shared types, default sizes and helpers for the bit-stream
//             packet arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package bitarb_pkg;

  // Arbiter state encoding; ABORT is only reachable when the timeout is built in
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } bitarb_state_t;

  localparam int BITARB_N_SRC_DEF   = 4;
  localparam int BITARB_TIMEOUT_DEF = 16;

  // Slot visited at offset 'off' after 'ptr' in an n-entry ring
  function automatic int unsigned rr_slot(input int unsigned ptr,
                                          input int unsigned off,
                                          input int unsigned n);
    return (ptr + off) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitarb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : bitarb_rr_pick
//  Brief    : Combinational round-robin picker. Returns the first requester
//             found searching ptr+1 .. ptr+N_SRC with wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module bitarb_rr_pick
  import bitarb_pkg::*;
#(
  parameter  int N_SRC = BITARB_N_SRC_DEF,
  localparam int GW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic             found,
  output logic [GW-1:0]    idx
);

  logic [GW-1:0] slot;

  // Walk the ring from the farthest offset back to the nearest so the
  // nearest requester after ptr is the last (winning) assignment
  always_comb begin
    found = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int off = N_SRC; off >= 1; off--) begin
      slot = GW'(rr_slot(32'(ptr), 32'(off), 32'(N_SRC)));
      if (req[slot]) begin
        found = 1'b1;
        idx   = slot;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitstream_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bitstream_pkt_arbiter
//  Brief    : Packet-granular round-robin arbiter sharing one bit detector
//             among N_SRC serial bit-stream sources. A grant is taken on an
//             SOP and held until the matching EOP transfers. Non-SOP beats
//             from sources that do not own the grant are drained as orphans.
//  Options  : BITARB_TIMEOUT_EN - abort a packet whose source stays idle for
//             TIMEOUT cycles by emitting a forced EOP beat.
//  Revision : 1.0 - initial release
// ============================================================================
module bitstream_pkt_arbiter
  import bitarb_pkg::*;
#(
  parameter  int N_SRC   = BITARB_N_SRC_DEF,
  parameter  int TIMEOUT = BITARB_TIMEOUT_DEF,
  localparam int GW      = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] i_sop,
  input  logic [N_SRC-1:0] i_eop,
  input  logic [N_SRC-1:0] i_valid,
  input  logic [N_SRC-1:0] inp,
  output logic [N_SRC-1:0] i_ready,
  output logic             outp,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  output logic             orphan_drop,
  output logic             timeout_abort
);

  if (N_SRC < 2 || TIMEOUT < 1) begin : g_param_check
    $error("bitstream_pkt_arbiter: N_SRC must be >= 2 and TIMEOUT >= 1");
  end

  bitarb_state_t    state_q, state_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic             busy_q;

  logic [N_SRC-1:0] sop_req;
  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  logic [N_SRC-1:0] own_mask;
  logic [N_SRC-1:0] orphan_mask;
  logic             beat_acc;

  // Raw combinational outputs, zeroed below while reset is asserted
  logic [N_SRC-1:0] ready_raw;
  logic             outp_raw, sop_raw, eop_raw, valid_raw, orphan_raw;
  logic             abort_raw;

`ifdef BITARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign sop_req = i_valid & i_sop;

  bitarb_rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .req   (sop_req),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, grant mux and orphan draining
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    outp_raw   = 1'b0;
    sop_raw    = 1'b0;
    eop_raw    = 1'b0;
    valid_raw  = 1'b0;
    abort_raw  = 1'b0;
    beat_acc   = 1'b0;
    own_mask   = '0;
`ifdef BITARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    // The granted source is never an orphan while a packet is open
    if (state_q != IDLE) begin
      own_mask[grant_q] = 1'b1;
    end
    orphan_mask = i_valid & ~i_sop & ~own_mask;
    ready_raw   = orphan_mask;
    orphan_raw  = |orphan_mask;

    case (state_q)
      IDLE: begin
        // Arbitration cycle only: no beat moves, SOP sources are held
        if (pick_found) begin
          grant_d = pick_idx;
          rr_d    = pick_idx;
          state_d = GRANT;
`ifdef BITARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      GRANT: begin
        outp_raw           = inp[grant_q];
        sop_raw            = i_sop[grant_q];
        eop_raw            = i_eop[grant_q];
        valid_raw          = i_valid[grant_q];
        ready_raw[grant_q] = o_ready;
        beat_acc           = i_valid[grant_q] & o_ready;
`ifdef BITARB_TIMEOUT_EN
        if (beat_acc) begin
          cnt_d = '0;
        end else if (!i_valid[grant_q]) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            state_d = ABORT;
          end
        end
`endif
        if (beat_acc && i_eop[grant_q]) begin
          state_d = IDLE;
        end
      end

`ifdef BITARB_TIMEOUT_EN
      ABORT: begin
        // Synthetic terminating beat; the stalled source is not served
        valid_raw = 1'b1;
        eop_raw   = 1'b1;
        if (o_ready) begin
          abort_raw = 1'b1;
          state_d   = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held
  always_comb begin
    i_ready     = reset_n ? ready_raw  : '0;
    outp        = reset_n & outp_raw;
    o_sop       = reset_n & sop_raw;
    o_eop       = reset_n & eop_raw;
    o_valid     = reset_n & valid_raw;
    orphan_drop = reset_n & orphan_raw;
    busy        = reset_n & busy_q;
    grant_id    = reset_n ? grant_q : '0;
  end

`ifdef BITARB_TIMEOUT_EN
  assign timeout_abort = reset_n & abort_raw;
`else
  assign timeout_abort = 1'b0;
`endif

  // State, round-robin pointer, grant and busy registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= GW'(N_SRC - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef BITARB_TIMEOUT_EN
  // Idle-cycle counter for the open packet
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitstream_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitstream_pkt_arbiter
//  Brief    : Directed self-checking bench for bitstream_pkt_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitstream_pkt_arbiter;

  localparam int N_SRC   = 4;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] i_sop, i_eop, i_valid, inp;
  logic       o_ready;
  logic [3:0] i_ready;
  logic       outp, o_sop, o_eop, o_valid;
  logic [1:0] grant_id;
  logic       busy, orphan_drop, timeout_abort;

  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int x0;

  bitstream_pkt_arbiter #(
    .N_SRC   (N_SRC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_sop         (i_sop),
    .i_eop         (i_eop),
    .i_valid       (i_valid),
    .inp           (inp),
    .i_ready       (i_ready),
    .outp          (outp),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .o_valid       (o_valid),
    .o_ready       (o_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .orphan_drop   (orphan_drop),
    .timeout_abort (timeout_abort)
  );

  always #5 clk = ~clk;

  // Count downstream transfers mid-cycle, where inputs are stable
  always @(negedge clk) begin
    if (o_valid && o_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_sop = '0; i_eop = '0; i_valid = '0; inp = '0;
  endtask

  initial begin
    reset_n = 1'b0; o_ready = 1'b1; clr();
    tick(); tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", i_ready, 0);
    chk("rst_orphan", orphan_drop, 0);
    chk("rst_tabort", timeout_abort, 0);

    // ---- 1: src2, 4-beat packet 1,0,1,0 ----
    reset_n = 1'b1;
    x0 = xfer_cnt;
    i_valid[2] = 1; i_sop[2] = 1; inp[2] = 1;
    #1;
    chk("t1_idle_valid", o_valid, 0);
    chk("t1_idle_ready", i_ready, 4'b0000);
    tick();
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_b0_valid", o_valid, 1);
    chk("t1_b0_sop", o_sop, 1);
    chk("t1_b0_bit", outp, 1);
    chk("t1_b0_ready", i_ready, 4'b0100);
    tick();
    i_sop[2] = 0; inp[2] = 0; #1;
    chk("t1_b1_bit", outp, 0);
    chk("t1_b1_sop", o_sop, 0);
    tick();
    inp[2] = 1; #1;
    chk("t1_b2_bit", outp, 1);
    tick();
    inp[2] = 0; i_eop[2] = 1; #1;
    chk("t1_b3_bit", outp, 0);
    chk("t1_b3_eop", o_eop, 1);
    tick();
    clr(); #1;
    chk("t1_end_busy", busy, 0);
    chk("t1_end_valid", o_valid, 0);
    chk("t1_xfers", xfer_cnt - x0, 4);

    // ---- 2: src0, src1, src3 request together from reset ----
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    i_valid = 4'b1011; i_sop = 4'b1011; i_eop = 4'b1011; inp = 4'b1001;
    tick();
    chk("t2_g0", grant_id, 0);
    chk("t2_g0_ready", i_ready, 4'b0001);
    chk("t2_g0_bit", outp, 1);
    tick();
    i_valid[0] = 0; i_sop[0] = 0; i_eop[0] = 0; #1;
    chk("t2_gap1_busy", busy, 0);
    chk("t2_gap1_valid", o_valid, 0);
    chk("t2_gap1_ready", i_ready, 4'b0000);
    tick();
    chk("t2_g1", grant_id, 1);
    chk("t2_g1_bit", outp, 0);
    chk("t2_g1_ready", i_ready, 4'b0010);
    tick();
    i_valid[1] = 0; i_sop[1] = 0; i_eop[1] = 0; #1;
    chk("t2_gap2_busy", busy, 0);
    tick();
    chk("t2_g3", grant_id, 3);
    chk("t2_g3_bit", outp, 1);
    tick();
    clr(); #1;
    chk("t2_end_busy", busy, 0);

    // ---- 3: single-beat packet on src1 under a 3-cycle stall ----
    x0 = xfer_cnt;
    i_valid[1] = 1; i_sop[1] = 1; i_eop[1] = 1; inp[1] = 1; o_ready = 0;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("t3_stall_valid", o_valid, 1);
      chk("t3_stall_ready", i_ready[1], 0);
      chk("t3_stall_grant", grant_id, 1);
      tick();
    end
    o_ready = 1; #1;
    chk("t3_go_ready", i_ready[1], 1);
    chk("t3_go_eop", o_eop, 1);
    tick();
    clr(); #1;
    chk("t3_end_busy", busy, 0);
    chk("t3_xfers", xfer_cnt - x0, 1);

    // ---- 4: orphan beat from src3 while src0 is granted ----
    i_valid[0] = 1; i_sop[0] = 1; inp[0] = 1;
    tick();
    i_valid[3] = 1; inp[3] = 1; #1;
    chk("t4_grant", grant_id, 0);
    chk("t4_ready", i_ready, 4'b1001);
    chk("t4_orphan", orphan_drop, 1);
    chk("t4_bit", outp, 1);
    chk("t4_sop", o_sop, 1);
    tick();
    i_valid[3] = 0; i_sop[0] = 0; i_eop[0] = 1; inp[0] = 0; #1;
    chk("t4_orphan_off", orphan_drop, 0);
    chk("t4_eop", o_eop, 1);
    chk("t4_bit2", outp, 0);
    tick();
    clr(); #1;
    chk("t4_end_busy", busy, 0);

    // ---- 5: reset in the middle of a src1 packet ----
    i_valid[1] = 1; i_sop[1] = 1; inp[1] = 1;
    tick();
    chk("t5_grant1", grant_id, 1);
    tick();
    i_sop[1] = 0; i_valid[0] = 1; i_sop[0] = 1; inp[0] = 1;
    reset_n = 1'b0; #1;
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_ready", i_ready, 0);
    chk("t5_rst_bit", outp, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant_id, 0);
    chk("t5_rst_orphan", orphan_drop, 0);
    tick(); tick();
    chk("t5_rst_busy2", busy, 0);
    reset_n = 1'b1;
    i_valid = 4'b0011; i_sop = 4'b0011; i_eop = 4'b0001;
    tick();
    chk("t5_winner", grant_id, 0);
    chk("t5_win_ready", i_ready, 4'b0001);
    tick();
    clr(); #1;
    chk("t5_end_busy", busy, 0);

`ifdef BITARB_TIMEOUT_EN
    // ---- 6: src2 opens a packet and goes silent ----
    i_valid[2] = 1; i_sop[2] = 1; inp[2] = 1;
    tick();
    chk("t6_grant", grant_id, 2);
    tick();
    i_valid[2] = 0; i_sop[2] = 0;
    for (int s = 0; s < 4; s++) begin
      chk("t6_idle_valid", o_valid, 0);
      tick();
    end
    o_ready = 0; #1;
    chk("t6_ab_valid", o_valid, 1);
    chk("t6_ab_eop", o_eop, 1);
    chk("t6_ab_sop", o_sop, 0);
    chk("t6_ab_bit", outp, 0);
    chk("t6_ab_ready", i_ready, 0);
    chk("t6_ab_pulse_early", timeout_abort, 0);
    tick();
    o_ready = 1; #1;
    chk("t6_ab_pulse", timeout_abort, 1);
    tick();
    i_valid[2] = 1; #1;
    chk("t6_late_orphan", orphan_drop, 1);
    chk("t6_late_ready", i_ready[2], 1);
    chk("t6_late_busy", busy, 0);
    tick();
    clr();
`else
    // ---- 6: without the timeout a silent source keeps its grant ----
    i_valid[2] = 1; i_sop[2] = 1; inp[2] = 1;
    tick();
    chk("t6_grant", grant_id, 2);
    tick();
    i_valid[2] = 0; i_sop[2] = 0;
    for (int s = 0; s < 8; s++) tick();
    chk("t6_hold_busy", busy, 1);
    chk("t6_hold_valid", o_valid, 0);
    chk("t6_no_abort", timeout_abort, 0);
    i_valid[2] = 1; i_eop[2] = 1; #1;
    chk("t6_close_eop", o_eop, 1);
    tick();
    clr(); #1;
    chk("t6_end_busy", busy, 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
